trap_sequencer: RTL and testbench
=================================

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 64: data/CSR width.
REQ-002 SHALL have parameter ALEN, default 64: address width.
REQ-003 SHALL have parameter INTR_LEN, default 32: mie/mip width; bits 16+ are platform interrupts.
REQ-004 SHALL have ports:
  clk  in  1  clock
  rst  in  1  reset, synchronous, active-high
  exc_valid  in  1  synchronous exception from exec stage
  exc_cause  in  4  exception code
  exc_pc  in  ALEN  faulting instruction PC
  exc_tval  in  XLEN  exception value
  xret_valid  in  1  MRET retiring
  pipe_idle  in  1  no instruction in flight
  next_pc  in  ALEN  PC of next unexecuted instruction
  mstatus  in  XLEN  current mstatus
  mie  in  INTR_LEN  interrupt enables
  mip  in  INTR_LEN  interrupts pending
  mtvec  in  XLEN  trap vector
  mepc  in  ALEN  current mepc
  privilege_mode  in  2  current privilege
  stall_fetch  out  1  hold fetch/issue
  trap_do_update  out  1  CSR trap-entry strobe
  trap_mcause  out  XLEN  mcause to write
  trap_mepc  out  ALEN  mepc to write
  trap_mtval  out  XLEN  mtval to write
  xret_do_update  out  1  CSR xret strobe
  xret_completing  out  1  trap follows xret; CSRs keep mepc
  xret_new_mstatus  out  XLEN  post-MRET mstatus
  xret_new_privilege_mode  out  2  post-MRET privilege
  redirect_valid  out  1  one-cycle PC redirect
  redirect_pc  out  ALEN  redirect target

Function
REQ-005 SHALL implement FSM states IDLE, DRAIN, TRAP, XRET, REDIRECT; all outputs registered.
REQ-006 int_pending = ((mie & mip) != 0) && (mstatus[3] || privilege_mode < 2'b11).
REQ-007 Interrupt select priority: bit 11 > bit 3 > bit 7 > lowest-index set bit in [INTR_LEN-1:16].
REQ-008 IDLE: exc_valid -> TRAP, latch mcause={0,exc_cause}, mepc=exc_pc, mtval=exc_tval; else xret_valid -> XRET; else int_pending -> DRAIN.
REQ-009 exc_valid wins over simultaneous xret_valid and int_pending.
REQ-010 DRAIN: stall_fetch=1; exc_valid -> TRAP as REQ-008; else on pipe_idle, re-evaluate int_pending: true -> TRAP, latch mcause={1,0...,code}, mepc=next_pc, mtval=0; false -> IDLE, stall released.
REQ-011 TRAP: trap_do_update=1 exactly one cycle; redirect_pc = mtvec[1:0]==01 && interrupt ? {mtvec[XLEN-1:2],2'b00}+4*code : {mtvec[XLEN-1:2],2'b00}; -> REDIRECT.
REQ-012 XRET: xret_do_update=1 one cycle; xret_new_mstatus = mstatus with MIE(3)=MPIE(7), MPIE=1, MPP[12:11]=00; xret_new_privilege_mode=mstatus[12:11]; redirect_pc=mepc; -> REDIRECT.
REQ-013 REDIRECT after XRET: if int_pending evaluated on post-xret mstatus/privilege, -> TRAP with mepc=mepc input, xret_completing=1 during that TRAP cycle, no redirect_valid; else redirect_valid=1 one cycle -> IDLE.
REQ-014 REDIRECT after TRAP: redirect_valid=1 one cycle -> IDLE.
REQ-015 stall_fetch=1 in every state except IDLE.
REQ-016 trap_do_update and xret_do_update SHALL never be asserted in the same cycle.
REQ-017 exc_valid/xret_valid ignored outside IDLE/DRAIN.

Reset
REQ-018 rst -> IDLE next cycle; all strobes, stall_fetch, redirect_valid 0; data outputs 0; mid-operation reset aborts without any strobe.

Verification
REQ-019 IDLE, exc_valid, cause 2, exc_pc 0x1000, mtvec 0x8000 -> trap_do_update 1 cycle, mcause 2, mepc 0x1000, redirect_pc 0x8000 next cycle.
REQ-020 mstatus.MIE=1, mie=mip=0x80, pipe_idle low 3 cycles -> stall held 3 cycles, then mcause 0x8000...0007, mepc=next_pc.
REQ-021 mip=mie=0x888, mtvec 0x8001 -> code 11, redirect_pc 0x802C.
REQ-022 MRET, mstatus MPIE=1 MPP=00, no pending -> new MIE=1, priv 00, redirect_pc=mepc.
REQ-023 MRET with MPIE=1 and mip&mie=0x80 -> xret strobe, then TRAP with xret_completing=1, no intervening redirect.
REQ-024 Interrupt withdrawn during DRAIN -> return to IDLE, no trap_do_update.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Pipeline-side bundle for the trap sequencer: exception/xret requests, CSR
// snapshot inputs, and the trap/xret CSR-update and PC-redirect outputs.
interface trap_sequencer_if #(
   parameter int XLEN     = 64,
   parameter int ALEN     = 64,
   parameter int INTR_LEN = 32
);
   logic                exc_valid;
   logic [3:0]          exc_cause;
   logic [ALEN-1:0]     exc_pc;
   logic [XLEN-1:0]     exc_tval;
   logic                xret_valid;
   logic                pipe_idle;
   logic [ALEN-1:0]     next_pc;
   logic [XLEN-1:0]     mstatus;
   logic [INTR_LEN-1:0] mie;
   logic [INTR_LEN-1:0] mip;
   logic [XLEN-1:0]     mtvec;
   logic [ALEN-1:0]     mepc;
   logic [1:0]          privilege_mode;

   logic                stall_fetch;
   logic                trap_do_update;
   logic [XLEN-1:0]     trap_mcause;
   logic [ALEN-1:0]     trap_mepc;
   logic [XLEN-1:0]     trap_mtval;
   logic                xret_do_update;
   logic                xret_completing;
   logic [XLEN-1:0]     xret_new_mstatus;
   logic [1:0]          xret_new_privilege_mode;
   logic                redirect_valid;
   logic [ALEN-1:0]     redirect_pc;

   modport master (
      output exc_valid, exc_cause, exc_pc, exc_tval, xret_valid, pipe_idle,
             next_pc, mstatus, mie, mip, mtvec, mepc, privilege_mode,
      input  stall_fetch, trap_do_update, trap_mcause, trap_mepc, trap_mtval,
             xret_do_update, xret_completing, xret_new_mstatus,
             xret_new_privilege_mode, redirect_valid, redirect_pc
   );

   modport slave (
      input  exc_valid, exc_cause, exc_pc, exc_tval, xret_valid, pipe_idle,
             next_pc, mstatus, mie, mip, mtvec, mepc, privilege_mode,
      output stall_fetch, trap_do_update, trap_mcause, trap_mepc, trap_mtval,
             xret_do_update, xret_completing, xret_new_mstatus,
             xret_new_privilege_mode, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET sequencer: drains the pipe for interrupts, strobes
// CSR trap-entry or xret updates, then issues a single-cycle PC redirect.
module trap_sequencer #(
   parameter int XLEN     = 64,
   parameter int ALEN     = 64,
   parameter int INTR_LEN = 32
) (
   input  logic             clk,
   input  logic             rst,
   trap_sequencer_if.slave  bus
);
   localparam int CW = (INTR_LEN > 1) ? $clog2(INTR_LEN) : 1;

   typedef enum logic [2:0] {IDLE, DRAIN, TRAP, XRET, REDIRECT} state_t;

   state_t          r_state, w_state;
   logic            r_stall, r_tdu, r_xdu, r_xc, r_rv;
   logic            w_tdu, w_xdu, w_xc, w_rv;
   logic [XLEN-1:0] r_mcause, r_mtval, r_xms, w_mcause, w_mtval, w_xms;
   logic [ALEN-1:0] r_mepc, r_rpc, w_mepc, w_rpc;
   logic [1:0]      r_xpriv, w_xpriv;
   logic            r_xret_trap, w_xret_trap;
   logic [CW-1:0]   r_code, w_code_q;

   logic [INTR_LEN-1:0] w_en;
   logic                w_int_pending, w_post_pending;
   logic [CW-1:0]       w_code;

   function automatic logic [CW-1:0] f_sel(input logic [INTR_LEN-1:0] en);
      logic [CW-1:0] code;
      logic          found;
      code  = '0;
      found = 1'b0;
      if (en[11])     code = CW'(11);
      else if (en[3]) code = CW'(3);
      else if (en[7]) code = CW'(7);
      else begin
         for (int unsigned i = 16; i < unsigned'(INTR_LEN); i++) begin
            if (!found && en[i]) begin
               code  = CW'(i);
               found = 1'b1;
            end
         end
      end
      return code;
   endfunction

   function automatic logic [XLEN-1:0] f_int_cause(input logic [CW-1:0] code);
      logic [XLEN-1:0] c;
      c = XLEN'(code);
      c[XLEN-1] = 1'b1;
      return c;
   endfunction

   // Vectored mode only offsets interrupts; exceptions always use the base.
   function automatic logic [ALEN-1:0] f_vec(input logic [XLEN-1:0] tvec,
                                             input logic [CW-1:0] code,
                                             input logic intr);
      logic [ALEN-1:0] base;
      base = ALEN'({tvec[XLEN-1:2], 2'b00});
      if (tvec[1:0] == 2'b01 && intr) base = base + (ALEN'(code) << 2);
      return base;
   endfunction

   always_comb begin
      w_en           = bus.mie & bus.mip;
      w_int_pending  = (|w_en) && (bus.mstatus[3] || bus.privilege_mode != 2'b11);
      w_post_pending = (|w_en) && (r_xms[3] || r_xpriv != 2'b11);
      w_code         = f_sel(w_en);
   end

   always_comb begin
      w_state     = r_state;
      w_tdu       = 1'b0;
      w_xdu       = 1'b0;
      w_xc        = 1'b0;
      w_rv        = 1'b0;
      w_mcause    = r_mcause;
      w_mepc      = r_mepc;
      w_mtval     = r_mtval;
      w_xms       = r_xms;
      w_xpriv     = r_xpriv;
      w_rpc       = r_rpc;
      w_xret_trap = r_xret_trap;
      w_code_q    = r_code;

      case (r_state)
         IDLE, DRAIN: begin
            if (bus.exc_valid) begin
               w_state  = TRAP;
               w_tdu    = 1'b1;
               w_mcause = XLEN'(bus.exc_cause);
               w_mepc   = bus.exc_pc;
               w_mtval  = bus.exc_tval;
               w_rpc    = f_vec(bus.mtvec, '0, 1'b0);
            end else if (r_state == IDLE) begin
               if (bus.xret_valid) begin
                  w_state         = XRET;
                  w_xdu           = 1'b1;
                  w_xms           = bus.mstatus;
                  w_xms[3]        = bus.mstatus[7];
                  w_xms[7]        = 1'b1;
                  w_xms[12:11]    = 2'b00;
                  w_xpriv         = bus.mstatus[12:11];
                  w_rpc           = bus.mepc;
               end else if (w_int_pending) begin
                  w_state = DRAIN;
               end
            end else if (bus.pipe_idle) begin
               if (w_int_pending) begin
                  w_state  = TRAP;
                  w_tdu    = 1'b1;
                  w_mcause = f_int_cause(w_code);
                  w_mepc   = bus.next_pc;
                  w_mtval  = '0;
                  w_rpc    = f_vec(bus.mtvec, w_code, 1'b1);
               end else begin
                  w_state = IDLE;
               end
            end
         end
         TRAP: begin
            w_state     = REDIRECT;
            w_rv        = 1'b1;
            w_xret_trap = 1'b0;
         end
         // Pending check uses the post-MRET enable state latched in r_xms/r_xpriv.
         XRET: begin
            w_state = REDIRECT;
            if (w_post_pending) begin
               w_xret_trap = 1'b1;
               w_code_q    = w_code;
            end else begin
               w_xret_trap = 1'b0;
               w_rv        = 1'b1;
            end
         end
         REDIRECT: begin
            if (r_xret_trap) begin
               w_state     = TRAP;
               w_tdu       = 1'b1;
               w_xc        = 1'b1;
               w_mcause    = f_int_cause(r_code);
               w_mepc      = bus.mepc;
               w_mtval     = '0;
               w_rpc       = f_vec(bus.mtvec, r_code, 1'b1);
               w_xret_trap = 1'b0;
            end else begin
               w_state = IDLE;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_stall     <= 1'b0;
         r_tdu       <= 1'b0;
         r_xdu       <= 1'b0;
         r_xc        <= 1'b0;
         r_rv        <= 1'b0;
         r_mcause    <= '0;
         r_mepc      <= '0;
         r_mtval     <= '0;
         r_xms       <= '0;
         r_xpriv     <= '0;
         r_rpc       <= '0;
         r_xret_trap <= 1'b0;
         r_code      <= '0;
      end else begin
         r_state     <= w_state;
         r_stall     <= (w_state != IDLE);
         r_tdu       <= w_tdu;
         r_xdu       <= w_xdu;
         r_xc        <= w_xc;
         r_rv        <= w_rv;
         r_mcause    <= w_mcause;
         r_mepc      <= w_mepc;
         r_mtval     <= w_mtval;
         r_xms       <= w_xms;
         r_xpriv     <= w_xpriv;
         r_rpc       <= w_rpc;
         r_xret_trap <= w_xret_trap;
         r_code      <= w_code_q;
      end
   end

   assign bus.stall_fetch             = r_stall;
   assign bus.trap_do_update          = r_tdu;
   assign bus.trap_mcause             = r_mcause;
   assign bus.trap_mepc               = r_mepc;
   assign bus.trap_mtval              = r_mtval;
   assign bus.xret_do_update          = r_xdu;
   assign bus.xret_completing         = r_xc;
   assign bus.xret_new_mstatus        = r_xms;
   assign bus.xret_new_privilege_mode = r_xpriv;
   assign bus.redirect_valid          = r_rv;
   assign bus.redirect_pc             = r_rpc;
endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a per-cycle vector table plus
// hand-written drain, MRET-then-trap, withdrawal and reset sequences.
module tb_trap_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   trap_sequencer_if #(.XLEN(64), .ALEN(64), .INTR_LEN(32)) bus ();
   trap_sequencer #(.XLEN(64), .ALEN(64), .INTR_LEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic        exc;
      logic [3:0]  cause;
      logic [63:0] epc, tval;
      logic        xret, pidle;
      logic [63:0] mstatus;
      logic [31:0] ie, ip;
      logic [63:0] mtvec, mepc;
      logic [1:0]  priv;
      logic        e_stall, e_tdu, e_xdu, e_rv, e_xc;
      logic [63:0] e_mcause, e_mepc, e_mtval, e_rpc, e_xms;
      logic [1:0]  e_xpriv;
   } vec_t;

   localparam logic [63:0] MC_B  = 64'h8000_0000_0000_000B;
   localparam logic [63:0] MC_7  = 64'h8000_0000_0000_0007;

   function automatic vec_t mk(
      logic exc, logic [3:0] cause, logic [63:0] epc, logic [63:0] tval,
      logic xret, logic pidle, logic [63:0] ms, logic [31:0] ie, logic [31:0] ip,
      logic [63:0] tvec, logic [63:0] mepc, logic [1:0] priv,
      logic st, logic tdu, logic xdu, logic rv, logic xc,
      logic [63:0] mc, logic [63:0] mpc, logic [63:0] mtv, logic [63:0] rpc,
      logic [63:0] xms, logic [1:0] xpv);
      vec_t v;
      v.exc = exc; v.cause = cause; v.epc = epc; v.tval = tval;
      v.xret = xret; v.pidle = pidle; v.mstatus = ms; v.ie = ie; v.ip = ip;
      v.mtvec = tvec; v.mepc = mepc; v.priv = priv;
      v.e_stall = st; v.e_tdu = tdu; v.e_xdu = xdu; v.e_rv = rv; v.e_xc = xc;
      v.e_mcause = mc; v.e_mepc = mpc; v.e_mtval = mtv; v.e_rpc = rpc;
      v.e_xms = xms; v.e_xpriv = xpv;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic st, input logic tdu,
                          input logic xdu, input logic rv, input logic xc);
      chk({tag, " stall"}, 64'(bus.stall_fetch), 64'(st));
      chk({tag, " trap_do_update"}, 64'(bus.trap_do_update), 64'(tdu));
      chk({tag, " xret_do_update"}, 64'(bus.xret_do_update), 64'(xdu));
      chk({tag, " redirect_valid"}, 64'(bus.redirect_valid), 64'(rv));
      chk({tag, " xret_completing"}, 64'(bus.xret_completing), 64'(xc));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.exc_valid = 1'b0; bus.exc_cause = '0; bus.exc_pc = '0; bus.exc_tval = '0;
      bus.xret_valid = 1'b0; bus.pipe_idle = 1'b1; bus.next_pc = 64'h2000;
      bus.mstatus = '0; bus.mie = '0; bus.mip = '0; bus.mtvec = 64'h8000;
      bus.mepc = 64'h4000; bus.privilege_mode = 2'b11;
   endtask

   task automatic int_case(input string tag, input logic [31:0] en, input logic [63:0] ms,
                           input logic [1:0] pv, input logic [63:0] tvec,
                           input logic [63:0] exp_mc, input logic [63:0] exp_rpc);
      idle_in();
      bus.mstatus = ms; bus.privilege_mode = pv; bus.mie = en; bus.mip = en;
      bus.mtvec = tvec; bus.next_pc = 64'h2400;
      step(); chk_ctl({tag, " drain"}, 1, 0, 0, 0, 0);
      step(); chk_ctl({tag, " trap"}, 1, 1, 0, 0, 0);
      chk({tag, " mcause"}, bus.trap_mcause, exp_mc);
      chk({tag, " mepc"}, bus.trap_mepc, 64'h2400);
      chk({tag, " mtval"}, bus.trap_mtval, 64'h0);
      chk({tag, " redirect_pc"}, bus.redirect_pc, exp_rpc);
      bus.mie = '0;
      step(); chk_ctl({tag, " redirect"}, 1, 0, 0, 1, 0);
      step(); chk_ctl({tag, " idle"}, 0, 0, 0, 0, 0);
   endtask

   vec_t tbl[$];

   initial begin
      tbl.push_back(mk(0,0,0,0,       0,1,64'h0,32'h0,32'h0,64'h8000,64'h4000,3, 0,0,0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(1,2,64'h1000,64'h55, 0,1,64'h0,32'h0,32'h0,64'h8000,64'h4000,3, 1,1,0,0,0, 2,64'h1000,64'h55,64'h8000,0,0));
      tbl.push_back(mk(1,7,64'h9999,64'h77, 0,1,64'h0,32'h0,32'h0,64'h8000,64'h4000,3, 1,0,0,1,0, 2,64'h1000,64'h55,64'h8000,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h0,32'h0,32'h0,64'h8000,64'h4000,3, 0,0,0,0,0, 2,64'h1000,64'h55,64'h8000,0,0));
      tbl.push_back(mk(1,5,64'h1100,64'h66, 1,1,64'h8,32'h80,32'h80,64'h8001,64'h4000,3, 1,1,0,0,0, 5,64'h1100,64'h66,64'h8000,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h0,32'h0,32'h0,64'h8000,64'h4000,3, 1,0,0,1,0, 5,64'h1100,64'h66,64'h8000,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h0,32'h0,32'h0,64'h8000,64'h4000,3, 0,0,0,0,0, 5,64'h1100,64'h66,64'h8000,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h8,32'h888,32'h888,64'h8001,64'h4000,3, 1,0,0,0,0, 5,64'h1100,64'h66,64'h8000,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h8,32'h888,32'h888,64'h8001,64'h4000,3, 1,1,0,0,0, MC_B,64'h2000,0,64'h802C,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h8,32'h0,32'h888,64'h8001,64'h4000,3, 1,0,0,1,0, MC_B,64'h2000,0,64'h802C,0,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h8,32'h0,32'h888,64'h8001,64'h4000,3, 0,0,0,0,0, MC_B,64'h2000,0,64'h802C,0,0));
      tbl.push_back(mk(0,0,0,0,       1,1,64'h80,32'h0,32'h0,64'h8000,64'h4000,3, 1,0,1,0,0, MC_B,64'h2000,0,64'h4000,64'h88,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h80,32'h0,32'h0,64'h8000,64'h4000,3, 1,0,0,1,0, MC_B,64'h2000,0,64'h4000,64'h88,0));
      tbl.push_back(mk(0,0,0,0,       0,1,64'h80,32'h0,32'h0,64'h8000,64'h4000,3, 0,0,0,0,0, MC_B,64'h2000,0,64'h4000,64'h88,0));

      idle_in();
      rst = 1'b1;
      step(); step();
      chk_ctl("reset", 0, 0, 0, 0, 0);
      chk("reset mcause", bus.trap_mcause, 64'h0);
      chk("reset redirect_pc", bus.redirect_pc, 64'h0);
      chk("reset xret_mstatus", bus.xret_new_mstatus, 64'h0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         string t;
         t = $sformatf("row%0d", i);
         bus.exc_valid = tbl[i].exc; bus.exc_cause = tbl[i].cause;
         bus.exc_pc = tbl[i].epc; bus.exc_tval = tbl[i].tval;
         bus.xret_valid = tbl[i].xret; bus.pipe_idle = tbl[i].pidle;
         bus.next_pc = 64'h2000; bus.mstatus = tbl[i].mstatus;
         bus.mie = tbl[i].ie; bus.mip = tbl[i].ip; bus.mtvec = tbl[i].mtvec;
         bus.mepc = tbl[i].mepc; bus.privilege_mode = tbl[i].priv;
         step();
         chk_ctl(t, tbl[i].e_stall, tbl[i].e_tdu, tbl[i].e_xdu, tbl[i].e_rv, tbl[i].e_xc);
         chk({t, " mcause"}, bus.trap_mcause, tbl[i].e_mcause);
         chk({t, " mepc"}, bus.trap_mepc, tbl[i].e_mepc);
         chk({t, " mtval"}, bus.trap_mtval, tbl[i].e_mtval);
         chk({t, " redirect_pc"}, bus.redirect_pc, tbl[i].e_rpc);
         chk({t, " xret_mstatus"}, bus.xret_new_mstatus, tbl[i].e_xms);
         chk({t, " xret_priv"}, 64'(bus.xret_new_privilege_mode), 64'(tbl[i].e_xpriv));
      end

      // Interrupt held off by a busy pipe for three cycles.
      idle_in();
      bus.mstatus = 64'h8; bus.mie = 32'h80; bus.mip = 32'h80;
      bus.pipe_idle = 1'b0; bus.next_pc = 64'h3000;
      for (int k = 0; k < 3; k++) begin
         step(); chk_ctl($sformatf("drain_wait%0d", k), 1, 0, 0, 0, 0);
      end
      bus.pipe_idle = 1'b1;
      step(); chk_ctl("drain_trap", 1, 1, 0, 0, 0);
      chk("drain_trap mcause", bus.trap_mcause, MC_7);
      chk("drain_trap mepc", bus.trap_mepc, 64'h3000);
      chk("drain_trap redirect_pc", bus.redirect_pc, 64'h8000);
      bus.mie = '0;
      step(); chk_ctl("drain_redirect", 1, 0, 0, 1, 0);
      step(); chk_ctl("drain_idle", 0, 0, 0, 0, 0);

      // MRET re-enables an already pending interrupt.
      idle_in();
      bus.mstatus = 64'h80; bus.mie = 32'h80; bus.mip = 32'h80;
      bus.mepc = 64'h4400; bus.xret_valid = 1'b1;
      step(); chk_ctl("xt_xret", 1, 0, 1, 0, 0);
      chk("xt_xret mstatus", bus.xret_new_mstatus, 64'h88);
      bus.xret_valid = 1'b0;
      step(); chk_ctl("xt_redirect", 1, 0, 0, 0, 0);
      step(); chk_ctl("xt_trap", 1, 1, 0, 0, 1);
      chk("xt_trap mcause", bus.trap_mcause, MC_7);
      chk("xt_trap mepc", bus.trap_mepc, 64'h4400);
      chk("xt_trap redirect_pc", bus.redirect_pc, 64'h8000);
      bus.mie = '0;
      step(); chk_ctl("xt_redirect2", 1, 0, 0, 1, 0);
      step(); chk_ctl("xt_idle", 0, 0, 0, 0, 0);

      // Interrupt withdrawn while draining.
      idle_in();
      bus.mstatus = 64'h8; bus.mie = 32'h8; bus.mip = 32'h8; bus.pipe_idle = 1'b0;
      step(); chk_ctl("wd_drain", 1, 0, 0, 0, 0);
      bus.mip = '0; bus.pipe_idle = 1'b1;
      step(); chk_ctl("wd_idle", 0, 0, 0, 0, 0);
      step(); chk_ctl("wd_idle2", 0, 0, 0, 0, 0);

      // Globally disabled in M-mode: no drain.
      idle_in();
      bus.mie = 32'h80; bus.mip = 32'h80;
      step(); chk_ctl("masked", 0, 0, 0, 0, 0);

      int_case("pri3", 32'h88, 64'h8, 2'b11, 64'h8001, 64'h8000_0000_0000_0003, 64'h800C);
      int_case("pri7", 32'h3_0080, 64'h8, 2'b11, 64'h8001, MC_7, 64'h801C);
      int_case("plat16", 32'h3_0000, 64'h0, 2'b00, 64'h8001, 64'h8000_0000_0000_0010, 64'h8040);
      int_case("mode3", 32'h80, 64'h8, 2'b11, 64'h8003, MC_7, 64'h8000);

      // Reset in the middle of a trap sequence.
      idle_in();
      bus.exc_valid = 1'b1; bus.exc_cause = 4'd3; bus.exc_pc = 64'h1234;
      step(); chk_ctl("mr_trap", 1, 1, 0, 0, 0);
      bus.exc_valid = 1'b0; rst = 1'b1;
      step(); chk_ctl("mr_reset", 0, 0, 0, 0, 0);
      chk("mr_reset mcause", bus.trap_mcause, 64'h0);
      chk("mr_reset mepc", bus.trap_mepc, 64'h0);
      chk("mr_reset redirect_pc", bus.redirect_pc, 64'h0);
      rst = 1'b0;
      step(); chk_ctl("mr_idle", 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
